sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: CPU/video arbiter for one single-port SRAM.
// Define SRAM_ARB_ROUNDROBIN_EN for round-robin arbitration.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCpuReq,
  input  logic        iCpuWe,
  input  logic [19:0] iCpuAddr,
  input  logic [7:0]  iCpuDataW,
  output logic        oCpuAck,
  output logic [7:0]  oCpuDataR,
  input  logic        iVidReq,
  input  logic [19:0] iVidAddr,
  output logic        oVidAck,
  output logic [7:0]  oVidDataR,
  output logic [19:0] oSramAddr,
  output logic [7:0]  oSramDataW,
  output logic        oSramWe,
  input  logic [7:0]  iSramDataR,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [3:0] count;
  logic       weFlag;
  logic       grantVid;
  logic       pickVid;
  logic       start;
  logic       lastCycle;

  assign start     = (state == IDLE) && (iCpuReq || iVidReq);
  assign lastCycle = (state == ACCESS) && (count == 4'd0);

`ifdef SRAM_ARB_ROUNDROBIN_EN
  logic lastVid;

  // On a tie the port that did not win last time goes first
  assign pickVid = iVidReq && (!iCpuReq || !lastVid);

  // Remember who was granted most recently
  always_ff @(posedge iClk) begin
    if (iRst) begin
      lastVid <= 1'b1;
    end else if (start) begin
      lastVid <= pickVid;
    end
  end
`else
  assign pickVid = iVidReq;
`endif

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = ACCESS;
      ACCESS:  if (lastCycle) nextState = RECOVER;
      RECOVER: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Latch the winner, count access cycles, capture read data
  always_ff @(posedge iClk) begin
    if (iRst) begin
      count      <= 4'd0;
      weFlag     <= 1'b0;
      grantVid   <= 1'b0;
      oSramAddr  <= 20'd0;
      oSramDataW <= 8'd0;
      oSramWe    <= 1'b0;
      oCpuDataR  <= 8'd0;
      oVidDataR  <= 8'd0;
    end else begin
      oSramWe <= (start && !pickVid && iCpuWe) ||
                 (state == ACCESS && !lastCycle && weFlag);
      if (start) begin
        count      <= 4'(WAIT_CYCLES - 1);
        grantVid   <= pickVid;
        weFlag     <= !pickVid && iCpuWe;
        oSramAddr  <= pickVid ? iVidAddr : iCpuAddr;
        oSramDataW <= pickVid ? 8'd0 : iCpuDataW;
      end else if (state == ACCESS) begin
        if (!lastCycle) begin
          count <= count - 4'd1;
        end else if (!weFlag) begin
          if (grantVid) begin
            oVidDataR <= iSramDataR;
          end else begin
            oCpuDataR <= iSramDataR;
          end
        end
      end
    end
  end

  // Status and completion pulses decoded from state
  always_comb begin
    oBusy   = (state != IDLE);
    oCpuAck = (state == RECOVER) && !grantVid;
    oVidAck = (state == RECOVER) && grantVid;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + randomized checks of sram_arbiter
// against a transaction-level timeline model.
module tb_sram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rstA = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [19:0] cpuAddr = '0, vidAddr = '0;
  logic [7:0]  cpuDataW = '0, sramDataR = '0;
  logic        vidReq = 1'b0;
  logic        cpuAck, vidAck, sramWe, busy;
  logic [7:0]  cpuDataR, vidDataR, sramDataW;
  logic [19:0] sramAddr;

  logic        rstB = 1'b1, vidReqB = 1'b0;
  logic [19:0] vidAddrB = '0, sramAddrB;
  logic        cpuAckB, vidAckB, sramWeB, busyB;
  logic [7:0]  cpuDataRB, vidDataRB, sramDataWB, sramDataRB;

  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(.WAIT_CYCLES(W)) dutA (
    .iClk(clk), .iRst(rstA),
    .iCpuReq(cpuReq), .iCpuWe(cpuWe), .iCpuAddr(cpuAddr),
    .iCpuDataW(cpuDataW), .oCpuAck(cpuAck), .oCpuDataR(cpuDataR),
    .iVidReq(vidReq), .iVidAddr(vidAddr), .oVidAck(vidAck),
    .oVidDataR(vidDataR), .oSramAddr(sramAddr),
    .oSramDataW(sramDataW), .oSramWe(sramWe),
    .iSramDataR(sramDataR), .oBusy(busy)
  );

  assign sramDataRB = sramAddrB[7:0] ^ 8'h3C;

  sram_arbiter #(.WAIT_CYCLES(1)) dutB (
    .iClk(clk), .iRst(rstB),
    .iCpuReq(1'b0), .iCpuWe(1'b0), .iCpuAddr(20'd0),
    .iCpuDataW(8'd0), .oCpuAck(cpuAckB), .oCpuDataR(cpuDataRB),
    .iVidReq(vidReqB), .iVidAddr(vidAddrB), .oVidAck(vidAckB),
    .oVidDataR(vidDataRB), .oSramAddr(sramAddrB),
    .oSramDataW(sramDataWB), .oSramWe(sramWeB),
    .iSramDataR(sramDataRB), .oBusy(busyB)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // Timeline model: a grant in cycle g occupies cycles g+1..g+W+1,
  // writes drive We in g+1..g+W, Ack lands in g+W+1.
  bit          mOn = 0;
  bit          mAct = 0;
  bit          mVid, mWe, mLastVid;
  int          mG;
  logic [19:0] mAddr;
  logic [7:0]  mDataW, mCpuR, mVidR;

  always @(negedge clk) begin
    int n;
    n = cyc;
    if (mOn) begin
      chk("busy", 32'(busy), 32'(mAct));
      chk("sramWe", 32'(sramWe),
          32'(mAct && mWe && n < mG + W + 1));
      chk("cpuAck", 32'(cpuAck),
          32'(mAct && !mVid && n == mG + W + 1));
      chk("vidAck", 32'(vidAck),
          32'(mAct && mVid && n == mG + W + 1));
      chk("sramAddr", 32'(sramAddr), 32'(mAddr));
      if (mAct && mWe)
        chk("sramDataW", 32'(sramDataW), 32'(mDataW));
      chk("cpuDataR", 32'(cpuDataR), 32'(mCpuR));
      chk("vidDataR", 32'(vidDataR), 32'(mVidR));
    end
    if (rstA) begin
      mOn = 1;
      mAct = 0;
      mLastVid = 1;
      mAddr = '0;
      mDataW = '0;
      mCpuR = '0;
      mVidR = '0;
    end else if (mAct) begin
      if (n == mG + W + 1) begin
        mAct = 0;
      end else if (n == mG + W && !mWe) begin
        if (mVid) mVidR = sramDataR;
        else mCpuR = sramDataR;
      end
    end else if (cpuReq || vidReq) begin
`ifdef SRAM_ARB_ROUNDROBIN_EN
      mVid = vidReq && (!cpuReq || !mLastVid);
`else
      mVid = vidReq;
`endif
      mLastVid = mVid;
      mAct = 1;
      mG = n;
      mWe = !mVid && cpuWe;
      mAddr = mVid ? vidAddr : cpuAddr;
      mDataW = cpuDataW;
    end
  end

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit grants[4];
    bit expG[4];
    bit aC, aV, seen;
    logic [7:0] expB[4];
    int lastAck, sCyc;

    expB[0] = 8'h3C; expB[1] = 8'h3D;
    expB[2] = 8'h3E; expB[3] = 8'h3F;

    nextCyc();
    nextCyc();
    rstA = 0;
    rstB = 0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst we", 32'(sramWe), 32'd0);
    chk("rst addr", 32'(sramAddr), 32'd0);
    chk("rst cpuR", 32'(cpuDataR), 32'd0);
    chk("rst vidR", 32'(vidDataR), 32'd0);

    // CPU write 0x12345 <- 0xA5
    nextCyc();
    cpuReq = 1; cpuWe = 1; cpuAddr = 20'h12345; cpuDataW = 8'hA5;
    @(negedge clk);
    chk("wr c0 we", 32'(sramWe), 32'd0);
    @(negedge clk);
    chk("wr c1 we", 32'(sramWe), 32'd1);
    chk("wr c1 addr", 32'(sramAddr), 32'h12345);
    chk("wr c1 data", 32'(sramDataW), 32'hA5);
    cpuAddr = 20'h00777; cpuDataW = 8'h11;
    @(negedge clk);
    chk("wr c2 we", 32'(sramWe), 32'd1);
    chk("wr c2 addr", 32'(sramAddr), 32'h12345);
    chk("wr c2 data", 32'(sramDataW), 32'hA5);
    @(negedge clk);
    chk("wr c3 we", 32'(sramWe), 32'd0);
    chk("wr c3 ack", 32'(cpuAck), 32'd1);
    nextCyc();
    cpuReq = 0;

    // CPU read 0x12345, SRAM returns 0x5A
    nextCyc();
    cpuReq = 1; cpuWe = 0; cpuAddr = 20'h12345; sramDataR = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd we", 32'(sramWe), 32'd0);
      chk("rd ack", 32'(cpuAck), 32'(i == 3));
    end
    chk("rd data", 32'(cpuDataR), 32'h5A);
    nextCyc();
    cpuReq = 0;

    // Reset in 2nd access cycle of a write aborts it
    nextCyc();
    cpuReq = 1; cpuWe = 1; cpuAddr = 20'h0ABCD; cpuDataW = 8'h3C;
    nextCyc();
    nextCyc();
    rstA = 1; cpuReq = 0;
    @(negedge clk);
    chk("abort in access", 32'(sramWe), 32'd1);
    nextCyc();
    rstA = 0;
    @(negedge clk);
    chk("abort we", 32'(sramWe), 32'd0);
    chk("abort ack", 32'(cpuAck), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort cpuR", 32'(cpuDataR), 32'd0);

    // Both ports requesting continuously
    nextCyc();
    cpuReq = 1; cpuWe = 0; cpuAddr = 20'h00100;
    vidReq = 1; vidAddr = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (cpuAck || vidAck) begin
          seen = 1;
          grants[k] = vidAck;
        end
      end
      if (!seen) begin
        nFails++;
        $display("FAIL grant %0d timeout: got none, expected an ack", k);
      end
    end
    nextCyc();
    cpuReq = 0; vidReq = 0;
`ifdef SRAM_ARB_ROUNDROBIN_EN
    expG[0] = 0; expG[1] = 1; expG[2] = 0; expG[3] = 1;
`else
    expG[0] = 1; expG[1] = 1; expG[2] = 1; expG[3] = 1;
`endif
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant%0d isVid", k), 32'(grants[k]), 32'(expG[k]));

    // Randomized traffic with occasional reset
    aC = 0; aV = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      aC = cpuAck;
      aV = vidAck;
      nextCyc();
      if (rstA) rstA = 0;
      else if ($urandom_range(0, 299) == 0) rstA = 1;
      if (cpuReq) begin
        if (aC) cpuReq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        cpuReq = 1;
        cpuWe = 1'($urandom);
      end
      if (vidReq) begin
        if (aV) vidReq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        vidReq = 1;
      end
      cpuAddr = 20'($urandom);
      cpuDataW = 8'($urandom);
      vidAddr = 20'($urandom);
      sramDataR = 8'($urandom);
    end
    cpuReq = 0; vidReq = 0;

    // WAIT_CYCLES=1 back-to-back video reads
    nextCyc();
    sCyc = cyc;
    vidReqB = 1; vidAddrB = 20'd0;
    lastAck = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (vidAckB) seen = 1;
      end
      if (!seen) begin
        nFails++;
        $display("FAIL vidB ack %0d timeout: got none, expected ack", k);
      end else begin
        chk($sformatf("vidB data%0d", k), 32'(vidDataRB), 32'(expB[k]));
        if (k == 0) chk("vidB latency", 32'(cyc - sCyc), 32'd2);
        else chk($sformatf("vidB gap%0d", k), 32'(cyc - lastAck), 32'd3);
        lastAck = cyc;
      end
      nextCyc();
      if (k == 3) vidReqB = 0;
      else vidAddrB = 20'(k + 1);
    end
    @(negedge clk);
    chk("vidB idle", 32'(busyB), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
